mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Arbitrates a single shared bus master port between the instruction fetch
// path and the MEM-stage data path. Data accesses win over fetches; each
// transaction is held on the bus until acknowledged or until MAX_WAIT bus
// cycles pass without an acknowledge, in which case it is aborted.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   if_ce_i, if_addr_i       fetch request and address
//   if_data_o                registered fetched instruction
//   stallreq_if_o            fetch stall request (combinational)
//   d_ce_i, d_we_i, d_sel_i  data request, write enable, byte select
//   d_addr_i, d_data_i       data address and store data
//   d_data_o                 registered load data
//   stallreq_mem_o           data stall request (combinational)
//   stall_i, flush_i         pipeline stall vector and flush
//   bus_*_o                  registered bus master outputs
//   bus_data_i, bus_ack_i    slave read data and acknowledge
//   bus_err_o                one-cycle pulse on transaction timeout

module mem_bus_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        stallreq_if_o,
    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    output logic [31:0] d_data_o,
    output logic        stallreq_mem_o,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic        busCyc_q, busCyc_d;
    logic        busStb_q, busStb_d;
    logic        busWe_q, busWe_d;
    logic [3:0]  busSel_q, busSel_d;
    logic [31:0] busAddr_q, busAddr_d;
    logic [31:0] busData_q, busData_d;
    logic [31:0] ifData_q, ifData_d;
    logic [31:0] dData_q, dData_d;
    logic        ifValid_q, ifValid_d;
    logic        dValid_q, dValid_d;
    logic        discard_q, discard_d;
    logic        busErr_q, busErr_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [7:0]  waitInc;
    logic        timeout;
    logic        unusedStall;

    // Only the IF/ID and MEM/WB hold bits matter to this block.
    assign unusedStall = ^{stall_i[5:4], stall_i[2], stall_i[0]};

    // Timeout fires on the edge that ends the MAX_WAIT-th unacknowledged
    // bus cycle, so cyc stays high for exactly MAX_WAIT cycles.
    assign waitInc = waitCnt_q + 8'd1;
    assign timeout = (waitInc == MAX_WAIT_C);

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busCyc_q  <= 1'b0;
            busStb_q  <= 1'b0;
            busWe_q   <= 1'b0;
            busSel_q  <= 4'd0;
            busAddr_q <= 32'd0;
            busData_q <= 32'd0;
            ifData_q  <= 32'd0;
            dData_q   <= 32'd0;
            ifValid_q <= 1'b0;
            dValid_q  <= 1'b0;
            discard_q <= 1'b0;
            busErr_q  <= 1'b0;
            waitCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            busCyc_q  <= busCyc_d;
            busStb_q  <= busStb_d;
            busWe_q   <= busWe_d;
            busSel_q  <= busSel_d;
            busAddr_q <= busAddr_d;
            busData_q <= busData_d;
            ifData_q  <= ifData_d;
            dData_q   <= dData_d;
            ifValid_q <= ifValid_d;
            dValid_q  <= dValid_d;
            discard_q <= discard_d;
            busErr_q  <= busErr_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Next-state logic. Valid flags drop once the consuming pipeline
    // register advances; a result only goes back to IDLE with the bus
    // released, which guarantees one idle bus cycle between transactions.
    always_comb begin
        state_d   = state_q;
        busCyc_d  = busCyc_q;
        busStb_d  = busStb_q;
        busWe_d   = busWe_q;
        busSel_d  = busSel_q;
        busAddr_d = busAddr_q;
        busData_d = busData_q;
        ifData_d  = ifData_q;
        dData_d   = dData_q;
        ifValid_d = ifValid_q & stall_i[1];
        dValid_d  = dValid_q & stall_i[3];
        discard_d = discard_q;
        busErr_d  = 1'b0;
        waitCnt_d = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (d_ce_i && !dValid_q) begin
                    state_d   = D_BUSY;
                    busCyc_d  = 1'b1;
                    busStb_d  = 1'b1;
                    busWe_d   = d_we_i;
                    busSel_d  = d_sel_i;
                    busAddr_d = d_addr_i;
                    busData_d = d_data_i;
                    waitCnt_d = 8'd0;
                end else if (if_ce_i && !ifValid_q) begin
                    state_d   = IF_BUSY;
                    busCyc_d  = 1'b1;
                    busStb_d  = 1'b1;
                    busWe_d   = 1'b0;
                    busSel_d  = 4'b1111;
                    busAddr_d = if_addr_i;
                    busData_d = 32'd0;
                    waitCnt_d = 8'd0;
                    discard_d = 1'b0;
                end
            end
            IF_BUSY: begin
                // A flush while the fetch is on the bus lets it finish but
                // marks the result as stale.
                if (bus_ack_i || timeout) begin
                    state_d   = IDLE;
                    busCyc_d  = 1'b0;
                    busStb_d  = 1'b0;
                    busErr_d  = ~bus_ack_i;
                    discard_d = 1'b0;
                    if (!(discard_q || flush_i)) begin
                        ifData_d  = bus_ack_i ? bus_data_i : 32'd0;
                        ifValid_d = 1'b1;
                    end
                end else begin
                    waitCnt_d = waitInc;
                    if (flush_i) begin
                        discard_d = 1'b1;
                    end
                end
            end
            D_BUSY: begin
                if (bus_ack_i || timeout) begin
                    state_d  = IDLE;
                    busCyc_d = 1'b0;
                    busStb_d = 1'b0;
                    busErr_d = ~bus_ack_i;
                    dData_d  = (bus_ack_i && !busWe_q) ? bus_data_i : 32'd0;
                    dValid_d = 1'b1;
                end else begin
                    waitCnt_d = waitInc;
                end
            end
            default: begin
                state_d  = IDLE;
                busCyc_d = 1'b0;
                busStb_d = 1'b0;
            end
        endcase

        if (flush_i) begin
            ifValid_d = 1'b0;
        end
    end

    assign stallreq_if_o  = ~rst & if_ce_i & ~ifValid_q;
    assign stallreq_mem_o = ~rst & d_ce_i & ~dValid_q;

    assign if_data_o  = ifData_q;
    assign d_data_o   = dData_q;
    assign bus_cyc_o  = busCyc_q;
    assign bus_stb_o  = busStb_q;
    assign bus_we_o   = busWe_q;
    assign bus_sel_o  = busSel_q;
    assign bus_addr_o = busAddr_q;
    assign bus_data_o = busData_q;
    assign bus_err_o  = busErr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter (MAX_WAIT = 4). Inputs change 1 ns
// after each rising edge and registered outputs are compared there too,
// well away from the next active edge.

module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        ifCe;
    logic [31:0] ifAddr;
    logic [31:0] ifData;
    logic        stallreqIf;
    logic        dCe;
    logic        dWe;
    logic [3:0]  dSel;
    logic [31:0] dAddr;
    logic [31:0] dDataIn;
    logic [31:0] dDataOut;
    logic        stallreqMem;
    logic [5:0]  stall;
    logic        flush;
    logic        busCyc;
    logic        busStb;
    logic        busWe;
    logic [3:0]  busSel;
    logic [31:0] busAddr;
    logic [31:0] busDataOut;
    logic [31:0] busDataIn;
    logic        busAck;
    logic        busErr;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (ifCe),
        .if_addr_i      (ifAddr),
        .if_data_o      (ifData),
        .stallreq_if_o  (stallreqIf),
        .d_ce_i         (dCe),
        .d_we_i         (dWe),
        .d_sel_i        (dSel),
        .d_addr_i       (dAddr),
        .d_data_i       (dDataIn),
        .d_data_o       (dDataOut),
        .stallreq_mem_o (stallreqMem),
        .stall_i        (stall),
        .flush_i        (flush),
        .bus_cyc_o      (busCyc),
        .bus_stb_o      (busStb),
        .bus_we_o       (busWe),
        .bus_sel_o      (busSel),
        .bus_addr_o     (busAddr),
        .bus_data_o     (busDataOut),
        .bus_data_i     (busDataIn),
        .bus_ack_i      (busAck),
        .bus_err_o      (busErr)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns past the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the request-side inputs of both pipeline ports.
    task automatic applyStimulus(input logic ifCeV, input logic [31:0] ifAddrV,
                                 input logic dCeV, input logic dWeV,
                                 input logic [3:0] dSelV, input logic [31:0] dAddrV,
                                 input logic [31:0] dDataV);
        ifCe    = ifCeV;
        ifAddr  = ifAddrV;
        dCe     = dCeV;
        dWe     = dWeV;
        dSel    = dSelV;
        dAddr   = dAddrV;
        dDataIn = dDataV;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 6'd0;
        flush     = 1'b0;
        busAck    = 1'b0;
        busDataIn = 32'd0;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        #3;
        // Reset state, with requests present to prove stall requests are masked.
        checkOutput("rst_stallreq_if", stallreqIf, 1'b0);
        checkOutput("rst_stallreq_mem", stallreqMem, 1'b0);
        checkOutput("rst_cyc", busCyc, 1'b0);
        checkOutput("rst_if_data", ifData, 32'h0);
        checkOutput("rst_err", busErr, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        nextCycle();
        checkOutput("idle_cyc", busCyc, 1'b0);

        // Single fetch, acked on its first bus cycle.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("f1_stallreq_req", stallreqIf, 1'b1);
        nextCycle();
        checkOutput("f1_cyc", busCyc, 1'b1);
        checkOutput("f1_stb", busStb, 1'b1);
        checkOutput("f1_addr", busAddr, 32'h100);
        checkOutput("f1_sel", busSel, 4'hF);
        checkOutput("f1_we", busWe, 1'b0);
        checkOutput("f1_stallreq_busy", stallreqIf, 1'b1);
        busAck    = 1'b1;
        busDataIn = 32'h3C010001;
        nextCycle();
        checkOutput("f1_cyc_drop", busCyc, 1'b0);
        checkOutput("f1_data", ifData, 32'h3C010001);
        checkOutput("f1_stallreq_done", stallreqIf, 1'b0);
        checkOutput("f1_err", busErr, 1'b0);
        busAck    = 1'b0;
        busDataIn = 32'hDEADDEAD;
        nextCycle();
        checkOutput("f1_valid_clear", stallreqIf, 1'b1);
        checkOutput("f1_idle_gap", busCyc, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();

        // Fetch and load in the same cycle: load first, fetch after a gap.
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        nextCycle();
        checkOutput("pri_cyc", busCyc, 1'b1);
        checkOutput("pri_addr_load", busAddr, 32'h40);
        checkOutput("pri_stallreq_if_a", stallreqIf, 1'b1);
        busAck    = 1'b1;
        busDataIn = 32'h11223344;
        nextCycle();
        checkOutput("pri_gap", busCyc, 1'b0);
        checkOutput("pri_d_data", dDataOut, 32'h11223344);
        checkOutput("pri_stallreq_mem", stallreqMem, 1'b0);
        checkOutput("pri_stallreq_if_b", stallreqIf, 1'b1);
        busAck = 1'b0;
        nextCycle();
        checkOutput("pri_fetch_cyc", busCyc, 1'b1);
        checkOutput("pri_fetch_addr", busAddr, 32'h200);
        checkOutput("pri_stallreq_if_c", stallreqIf, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busAck    = 1'b1;
        busDataIn = 32'h55667788;
        nextCycle();
        checkOutput("pri_if_data", ifData, 32'h55667788);
        checkOutput("pri_stallreq_if_d", stallreqIf, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busAck = 1'b0;
        nextCycle();

        // Store with ack on the third bus cycle.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h80, 32'h0000BEEF);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("st_cyc", busCyc, 1'b1);
            checkOutput("st_we", busWe, 1'b1);
            checkOutput("st_sel", busSel, 4'b0011);
            checkOutput("st_addr", busAddr, 32'h80);
            checkOutput("st_wdata", busDataOut, 32'h0000BEEF);
            checkOutput("st_stallreq", stallreqMem, 1'b1);
            if (i == 2) begin
                busAck    = 1'b1;
                busDataIn = 32'hCAFEF00D;
            end
            nextCycle();
        end
        checkOutput("st_cyc_drop", busCyc, 1'b0);
        checkOutput("st_d_data", dDataOut, 32'h0);
        checkOutput("st_stallreq_done", stallreqMem, 1'b0);
        checkOutput("st_err", busErr, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busAck = 1'b0;
        nextCycle();

        // Ack arrives on the same cycle the timeout would fire: ack wins.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h90, 32'h0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("race_cyc", busCyc, 1'b1);
            if (i == 3) begin
                busAck    = 1'b1;
                busDataIn = 32'hA5A5A5A5;
            end
            nextCycle();
        end
        checkOutput("race_d_data", dDataOut, 32'hA5A5A5A5);
        checkOutput("race_no_err", busErr, 1'b0);
        checkOutput("race_cyc_drop", busCyc, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busAck = 1'b0;
        nextCycle();

        // Load never acknowledged: abort after 4 wait cycles.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hA0, 32'h0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_cyc", busCyc, 1'b1);
            checkOutput("to_err_low", busErr, 1'b0);
            nextCycle();
        end
        checkOutput("to_cyc_drop", busCyc, 1'b0);
        checkOutput("to_err_pulse", busErr, 1'b1);
        checkOutput("to_d_data", dDataOut, 32'h0);
        checkOutput("to_stallreq", stallreqMem, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("to_err_once", busErr, 1'b0);

        // Fetch completes while IF/ID is held: result held, no refetch.
        stall = 6'b000010;
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("hold_cyc", busCyc, 1'b1);
        busAck    = 1'b1;
        busDataIn = 32'h0BADC0DE;
        nextCycle();
        checkOutput("hold_if_data", ifData, 32'h0BADC0DE);
        busAck    = 1'b0;
        busDataIn = 32'h0;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("hold_no_fetch", busCyc, 1'b0);
            checkOutput("hold_data_kept", ifData, 32'h0BADC0DE);
            checkOutput("hold_stallreq", stallreqIf, 1'b0);
        end
        stall = 6'd0;
        nextCycle();
        checkOutput("hold_valid_clear", stallreqIf, 1'b1);
        checkOutput("hold_cyc_after", busCyc, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();

        // Flush during a fetch: bus completes, result not marked valid.
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("fl_cyc", busCyc, 1'b1);
        flush = 1'b1;
        nextCycle();
        checkOutput("fl_still_on_bus", busCyc, 1'b1);
        flush     = 1'b0;
        busAck    = 1'b1;
        busDataIn = 32'h77777777;
        nextCycle();
        checkOutput("fl_cyc_drop", busCyc, 1'b0);
        checkOutput("fl_not_valid", stallreqIf, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busAck = 1'b0;
        nextCycle();

        // Reset in the middle of a load abandons it.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hB0, 32'h0);
        nextCycle();
        checkOutput("mr_cyc", busCyc, 1'b1);
        #2;
        rst       = 1'b1;
        busAck    = 1'b1;
        busDataIn = 32'h12345678;
        #1;
        checkOutput("mr_async_cyc", busCyc, 1'b0);
        checkOutput("mr_async_stb", busStb, 1'b0);
        checkOutput("mr_async_addr", busAddr, 32'h0);
        checkOutput("mr_async_sel", busSel, 4'h0);
        checkOutput("mr_async_if_data", ifData, 32'h0);
        checkOutput("mr_async_d_data", dDataOut, 32'h0);
        checkOutput("mr_stallreq_mem", stallreqMem, 1'b0);
        nextCycle();
        checkOutput("mr_err", busErr, 1'b0);
        checkOutput("mr_d_data_held", dDataOut, 32'h0);
        rst    = 1'b0;
        busAck = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hC0, 32'h0);
        #1;
        checkOutput("mr_stallreq_after", stallreqMem, 1'b1);
        nextCycle();
        checkOutput("mr_idle_start", busCyc, 1'b1);
        checkOutput("mr_idle_addr", busAddr, 32'hC0);
        busAck    = 1'b1;
        busDataIn = 32'h0F0F0F0F;
        nextCycle();
        checkOutput("mr_load_data", dDataOut, 32'h0F0F0F0F);
        checkOutput("mr_err_after", busErr, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busAck = 1'b0;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
